lvds_rx_word_align: RTL

- Receive-side alignment controller for the SGMII LVDS path; drives the deserializer bit-slip input (i_RxBitSlip of the LVDS transceiver wrapper).
- Consumes the decoded code-group stream: one group per clock from the 8b10b decoder, in the recovered-clock domain.
- Hunts for commas, slips one bit at a time until commas decode cleanly, then declares sync.
- Monitors code-group errors and drops sync after sustained errors, in the style of 802.3 clause 36.

---
 rtl/lvds_rx_word_align_pkg.sv | 24 ++
 rtl/lvds_rx_word_align_err_monitor.sv | 57 +++++
 rtl/lvds_rx_word_align.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/lvds_rx_word_align_pkg.sv
`default_nettype none
// lvds_rx_word_align_pkg -- state encoding, comma constants and comma matcher for the word aligner.
// Rev 1.0
package lvds_rx_word_align_pkg;

  typedef enum logic [2:0] {
    ST_SEARCH  = 3'd0,
    ST_SLIP    = 3'd1,
    ST_SETTLE  = 3'd2,
    ST_ACQUIRE = 3'd3,
    ST_SYNC    = 3'd4
  } state_t;

  localparam logic [7:0] K28_5 = 8'hBC;
  localparam logic [7:0] K28_1 = 8'h3C;
  localparam logic [7:0] K28_7 = 8'hFC;

  // A comma only counts when the decoder reports the group as clean.
  function automatic logic is_comma(input logic [7:0] grp, input logic ctrl, input logic invalid);
    return ctrl && !invalid && ((grp == K28_5) || (grp == K28_1) || (grp == K28_7));
  endfunction

endpackage
`default_nettype wire

// File: rtl/lvds_rx_word_align_err_monitor.sv
`default_nettype none
// lvds_rx_err_monitor -- in-sync error/good-run hysteresis; flags loss of sync on the error that reaches LOSS_ERRS.
// Rev 1.0
module lvds_rx_err_monitor #(
  parameter int LOSS_ERRS = 4,
  parameter int GOOD_RUN  = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic strobe,
  input  logic invalid,
  output logic lose_sync
);

  localparam logic [3:0] LOSS_TARGET = 4'(LOSS_ERRS);
  localparam logic [3:0] GOOD_TARGET = 4'(GOOD_RUN);

  logic [3:0] err_cnt;
  logic [3:0] err_nxt;
  logic [3:0] good_cnt;
  logic [3:0] good_nxt;

  assign lose_sync = strobe && !clear && invalid && ((err_cnt + 4'd1) == LOSS_TARGET);

  always_comb begin
    err_nxt  = err_cnt;
    good_nxt = good_cnt;
    if (clear || lose_sync) begin
      err_nxt  = 4'd0;
      good_nxt = 4'd0;
    end else if (strobe) begin
      if (invalid) begin
        err_nxt  = err_cnt + 4'd1;
        good_nxt = 4'd0;
      end else if (((good_cnt + 4'd1) == GOOD_TARGET) && (err_cnt != 4'd0)) begin
        err_nxt  = err_cnt - 4'd1;
        good_nxt = 4'd0;
      end else if (good_cnt != GOOD_TARGET) begin
        // With no errors outstanding the run length just parks at GOOD_RUN.
        good_nxt = good_cnt + 4'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt  <= 4'd0;
      good_cnt <= 4'd0;
    end else begin
      err_cnt  <= err_nxt;
      good_cnt <= good_nxt;
    end
  end

endmodule
`default_nettype wire

// File: rtl/lvds_rx_word_align.sv
`default_nettype none
// lvds_rx_word_align -- comma hunt and bit-slip alignment controller for the SGMII LVDS receive path.
// Rev 1.0
module lvds_rx_word_align
  import lvds_rx_word_align_pkg::*;
#(
  parameter int SEARCH_WINDOW = 64,
  parameter int SLIP_SETTLE   = 8,
  parameter int ACQ_COMMAS    = 3,
  parameter int LOSS_ERRS     = 4,
  parameter int GOOD_RUN      = 4
) (
  input  logic       i_Clk,
  input  logic       i_ARst_L,
  input  logic       i_Enable,
  input  logic [7:0] i8_RxCodeGroup,
  input  logic       i_RxCodeCtrl,
  input  logic       i_RxCodeInvalid,
  output logic       o_RxBitSlip,
  output logic       o_Synced,
  output logic [7:0] o8_SlipCnt,
  output logic [2:0] o3_State
);

  localparam logic [7:0] WIN_LAST    = 8'(SEARCH_WINDOW - 1);
  localparam logic [7:0] SETTLE_LAST = 8'(SLIP_SETTLE - 1);
  localparam logic [3:0] ACQ_TARGET  = 4'(ACQ_COMMAS);

  state_t     state;
  state_t     state_nxt;
  logic [7:0] win;
  logic [7:0] win_nxt;
  logic [7:0] settle;
  logic [7:0] settle_nxt;
  logic [7:0] slip_cnt;
  logic [7:0] slip_cnt_nxt;
  logic [3:0] comma_cnt;
  logic [3:0] comma_cnt_nxt;
  logic       slip;
  logic       slip_nxt;
  logic       synced;
  logic       synced_nxt;
  logic       comma;
  logic       mon_active;
  logic       lose_sync;

  assign comma      = is_comma(i8_RxCodeGroup, i_RxCodeCtrl, i_RxCodeInvalid);
  assign mon_active = i_Enable && (state == ST_SYNC);

  lvds_rx_err_monitor #(
    .LOSS_ERRS (LOSS_ERRS),
    .GOOD_RUN  (GOOD_RUN)
  ) u_err_mon (
    .clk       (i_Clk),
    .rst_n     (i_ARst_L),
    .clear     (!mon_active),
    .strobe    (mon_active),
    .invalid   (i_RxCodeInvalid),
    .lose_sync (lose_sync)
  );

  always_comb begin
    state_nxt     = state;
    win_nxt       = win;
    settle_nxt    = settle;
    slip_cnt_nxt  = slip_cnt;
    comma_cnt_nxt = comma_cnt;
    slip_nxt      = 1'b0;
    if (!i_Enable) begin
      state_nxt     = ST_SEARCH;
      win_nxt       = 8'd0;
      settle_nxt    = 8'd0;
      comma_cnt_nxt = 4'd0;
    end else begin
      case (state)
        ST_SEARCH: begin
          if (comma) begin
            comma_cnt_nxt = 4'd1;
            win_nxt       = 8'd0;
            state_nxt     = (ACQ_TARGET == 4'd1) ? ST_SYNC : ST_ACQUIRE;
          end else if (win == WIN_LAST) begin
            win_nxt   = 8'd0;
            state_nxt = ST_SLIP;
          end else begin
            win_nxt = win + 8'd1;
          end
        end
        ST_SLIP: begin
          slip_nxt = 1'b1;
          if (slip_cnt != 8'hFF) slip_cnt_nxt = slip_cnt + 8'd1;
          settle_nxt = 8'd0;
          state_nxt  = ST_SETTLE;
        end
        ST_SETTLE: begin
          // Groups here still carry the old alignment through the decoder pipeline.
          if (settle == SETTLE_LAST) begin
            settle_nxt = 8'd0;
            win_nxt    = 8'd0;
            state_nxt  = ST_SEARCH;
          end else begin
            settle_nxt = settle + 8'd1;
          end
        end
        ST_ACQUIRE: begin
          if (i_RxCodeInvalid) begin
            win_nxt       = 8'd0;
            comma_cnt_nxt = 4'd0;
            state_nxt     = ST_SLIP;
          end else if (comma) begin
            comma_cnt_nxt = comma_cnt + 4'd1;
            win_nxt       = 8'd0;
            if ((comma_cnt + 4'd1) == ACQ_TARGET) state_nxt = ST_SYNC;
          end else if (win == WIN_LAST) begin
            win_nxt       = 8'd0;
            comma_cnt_nxt = 4'd0;
            state_nxt     = ST_SLIP;
          end else begin
            win_nxt = win + 8'd1;
          end
        end
        ST_SYNC: begin
          if (lose_sync) begin
            win_nxt       = 8'd0;
            comma_cnt_nxt = 4'd0;
            state_nxt     = ST_SEARCH;
          end
        end
        default: begin
          state_nxt = ST_SEARCH;
        end
      endcase
    end
    synced_nxt = (state_nxt == ST_SYNC);
  end

  always_ff @(posedge i_Clk or negedge i_ARst_L) begin
    if (!i_ARst_L) begin
      state     <= ST_SEARCH;
      win       <= 8'd0;
      settle    <= 8'd0;
      slip_cnt  <= 8'd0;
      comma_cnt <= 4'd0;
      slip      <= 1'b0;
      synced    <= 1'b0;
    end else begin
      state     <= state_nxt;
      win       <= win_nxt;
      settle    <= settle_nxt;
      slip_cnt  <= slip_cnt_nxt;
      comma_cnt <= comma_cnt_nxt;
      slip      <= slip_nxt;
      synced    <= synced_nxt;
    end
  end

  assign o_RxBitSlip = slip;
  assign o_Synced    = synced;
  assign o8_SlipCnt  = slip_cnt;
  assign o3_State    = state;

endmodule
`default_nettype wire
